// File: rtl/br_pkg.sv
// Shared encodings for the branch resolve block: op kinds, RV32I branch funct3
// values and the controller state enum.
package br_pkg;

    localparam logic [1:0] KIND_COND = 2'b00;
    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;
    localparam logic [1:0] KIND_RSVD = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/br_cmp.sv
// Operand comparator: equality plus signed/unsigned less-than.
module br_cmp (
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic        i_unsigned,
    output logic        o_equal,
    output logic        o_less
);

    assign o_equal = (i_rs1 == i_rs2);
    assign o_less  = i_unsigned ? (i_rs1 < i_rs2)
                                : ($signed(i_rs1) < $signed(i_rs2));

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves one control-transfer op at a time: latch, evaluate for one cycle,
// then hold the next-PC result until fetch takes it.
//
// state   | meaning
// IDLE    | ready for a new op
// EVAL    | comparing latched operands, computing target
// RESP    | result presented, waiting for i_redir_ready
module branch_resolve_ctrl
    import br_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_br_valid,
    output logic             o_br_ready,
    input  logic [1:0]       i_kind,
    input  logic [2:0]       i_funct3,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_imm,
    input  logic [31:0]      i_rs1Data,
    input  logic [31:0]      i_rs2Data,
    input  logic             i_kill,
    output logic             o_redir_valid,
    input  logic             i_redir_ready,
    output logic [31:0]      o_redir_pc,
    output logic             o_taken,
    output logic             o_misalign,
    output logic [CNT_W-1:0] o_taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q;
    logic [1:0]       kind_q;
    logic [2:0]       funct3_q;
    logic [31:0]      pc_q, imm_q, rs1_q, rs2_q;
    logic [31:0]      redir_pc_q;
    logic             taken_q, misalign_q;
    logic [CNT_W-1:0] cnt_q;

    logic        equal, less;
    logic        cond_taken, taken_d, misalign_d;
    logic [31:0] target, redir_pc_d;

    br_cmp u_cmp (
        .i_rs1      (rs1_q),
        .i_rs2      (rs2_q),
        .i_unsigned (funct3_q[1]),
        .o_equal    (equal),
        .o_less     (less)
    );

    always_comb begin
        cond_taken = 1'b0;
        case (funct3_q)
            F3_BEQ:          cond_taken = equal;
            F3_BNE:          cond_taken = ~equal;
            F3_BLT, F3_BLTU: cond_taken = less;
            F3_BGE, F3_BGEU: cond_taken = ~less;
            default:         cond_taken = 1'b0;
        endcase
        taken_d    = (kind_q == KIND_JAL) || (kind_q == KIND_JALR) || cond_taken;
        target     = (kind_q == KIND_JALR) ? ((rs1_q + imm_q) & ~32'h1) : (pc_q + imm_q);
        redir_pc_d = taken_d ? target : (pc_q + 32'd4);
        misalign_d = taken_d & target[1];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            kind_q     <= '0;
            funct3_q   <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            redir_pc_q <= '0;
            taken_q    <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else if (i_kill) begin
            state_q    <= ST_IDLE;
            taken_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (i_br_valid) begin
                    kind_q   <= i_kind;
                    funct3_q <= i_funct3;
                    pc_q     <= i_pc;
                    imm_q    <= i_imm;
                    rs1_q    <= i_rs1Data;
                    rs2_q    <= i_rs2Data;
                    state_q  <= ST_EVAL;
                end
                ST_EVAL: begin
                    redir_pc_q <= redir_pc_d;
                    taken_q    <= taken_d;
                    misalign_q <= misalign_d;
                    state_q    <= ST_RESP;
                end
                ST_RESP: if (i_redir_ready) begin
                    if (taken_q && !misalign_q && cnt_q != CNT_MAX)
                        cnt_q <= cnt_q + 1'b1;
                    taken_q    <= 1'b0;
                    misalign_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_br_ready    = (state_q == ST_IDLE) & ~i_kill;
    assign o_redir_valid = (state_q == ST_RESP);
    assign o_redir_pc    = redir_pc_q;
    assign o_taken       = taken_q;
    assign o_misalign    = misalign_q;
    assign o_taken_cnt   = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl with a 2-bit taken counter.
module tb_branch_resolve_ctrl;
    import br_pkg::*;

    localparam int CW = 2;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_br_valid = 1'b0;
    logic          o_br_ready;
    logic [1:0]    i_kind = '0;
    logic [2:0]    i_funct3 = '0;
    logic [31:0]   i_pc = '0, i_imm = '0, i_rs1Data = '0, i_rs2Data = '0;
    logic          i_kill = 1'b0;
    logic          o_redir_valid;
    logic          i_redir_ready = 1'b1;
    logic [31:0]   o_redir_pc;
    logic          o_taken, o_misalign;
    logic [CW-1:0] o_taken_cnt;

    typedef struct {
        logic [31:0]   pc;
        logic          taken;
        logic          mis;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 i_clk = ~i_clk;

    branch_resolve_ctrl #(.CNT_W(CW)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_br_valid    (i_br_valid),
        .o_br_ready    (o_br_ready),
        .i_kind        (i_kind),
        .i_funct3      (i_funct3),
        .i_pc          (i_pc),
        .i_imm         (i_imm),
        .i_rs1Data     (i_rs1Data),
        .i_rs2Data     (i_rs2Data),
        .i_kill        (i_kill),
        .o_redir_valid (o_redir_valid),
        .i_redir_ready (i_redir_ready),
        .o_redir_pc    (o_redir_pc),
        .o_taken       (o_taken),
        .o_misalign    (o_misalign),
        .o_taken_cnt   (o_taken_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on every completed handshake, then check the counter one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_reset && !i_kill && o_redir_valid && i_redir_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", o_redir_pc, 32'hDEAD_BEEF);
                end else begin
                    e = sb_q.pop_front();
                    chk("redir_pc", o_redir_pc, e.pc);
                    chk("taken", {31'd0, o_taken}, {31'd0, e.taken});
                    chk("misalign", {31'd0, o_misalign}, {31'd0, e.mis});
                    @(negedge i_clk);
                    chk("taken_cnt", {30'd0, o_taken_cnt}, {30'd0, e.cnt});
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!o_br_ready && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (!o_br_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Leaves the caller at posedge+1 of the EVAL cycle.
    task automatic issue(input logic [1:0] kind, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        wait_ready();
        i_br_valid = 1'b1;
        i_kind = kind; i_funct3 = f3; i_pc = pc; i_imm = imm;
        i_rs1Data = rs1; i_rs2Data = rs2;
        @(posedge i_clk); #1;
        i_br_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic m, input logic [CW-1:0] c);
        exp_t e;
        e.pc = pc; e.taken = t; e.mis = m; e.cnt = c;
        sb_q.push_back(e);
    endtask

    task automatic run_op(input logic [1:0] kind, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] epc, input logic et, input logic em,
                          input logic [CW-1:0] ec);
        push(epc, et, em, ec);
        issue(kind, f3, pc, imm, rs1, rs2);
        @(negedge i_clk);
        chk("lat_eval_valid", {31'd0, o_redir_valid}, 32'd0);
        @(negedge i_clk);
        chk("lat_resp_valid", {31'd0, o_redir_valid}, 32'd1);
        @(posedge i_clk); #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_valid", {31'd0, o_redir_valid}, 32'd0);
        chk("rst_pc", o_redir_pc, 32'd0);
        chk("rst_cnt", {30'd0, o_taken_cnt}, 32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("rst_ready", {31'd0, o_br_ready}, 32'd1);

        run_op(KIND_COND, F3_BEQ, 32'h100, 32'h20, 32'h12345678, 32'h12345678, 32'h120, 1, 0, 2'd1);
        run_op(KIND_COND, F3_BLT, 32'h200, 32'h40, 32'hFFFFFFFF, 32'h1, 32'h240, 1, 0, 2'd2);
        run_op(KIND_COND, F3_BLTU, 32'h200, 32'h40, 32'hFFFFFFFF, 32'h1, 32'h204, 0, 0, 2'd2);
        run_op(KIND_JALR, 3'b000, 32'h300, 32'h2, 32'h1001, 32'h0, 32'h1002, 1, 1, 2'd2);

        // Kill during EVAL: no response, counter untouched.
        issue(KIND_JAL, 3'b000, 32'h900, 32'h10, 32'h0, 32'h0);
        i_kill = 1'b1;
        @(negedge i_clk);
        chk("kill_ready_low", {31'd0, o_br_ready}, 32'd0);
        @(posedge i_clk); #1;
        i_kill = 1'b0;
        @(negedge i_clk);
        chk("kill_eval_ready", {31'd0, o_br_ready}, 32'd1);
        n = 0;
        repeat (3) begin
            if (o_redir_valid) n++;
            @(negedge i_clk);
        end
        chk("kill_eval_novalid", n, 32'd0);
        chk("kill_eval_cnt", {30'd0, o_taken_cnt}, 32'd2);

        // Kill during RESP together with ready: kill wins.
        issue(KIND_JAL, 3'b000, 32'hA00, 32'h10, 32'h0, 32'h0);
        @(posedge i_clk); #1;
        i_kill = 1'b1;
        @(posedge i_clk); #1;
        i_kill = 1'b0;
        @(negedge i_clk);
        chk("kill_resp_valid", {31'd0, o_redir_valid}, 32'd0);
        chk("kill_resp_taken", {31'd0, o_taken}, 32'd0);
        chk("kill_resp_cnt", {30'd0, o_taken_cnt}, 32'd2);

        run_op(KIND_JALR, 3'b000, 32'h300, 32'h3, 32'h1001, 32'h0, 32'h1004, 1, 0, 2'd3);
        run_op(KIND_COND, F3_BGE, 32'hFFFFFFFC, 32'h40, 32'h1, 32'h5, 32'h0, 0, 0, 2'd3);
        run_op(KIND_COND, 3'b010, 32'h500, 32'h40, 32'h7, 32'h7, 32'h504, 0, 0, 2'd3);
        run_op(KIND_JAL, 3'b000, 32'h400, 32'hFFFFFFF8, 32'h0, 32'h0, 32'h3F8, 1, 0, 2'd3);
        run_op(KIND_RSVD, F3_BNE, 32'h600, 32'h10, 32'h3, 32'h4, 32'h610, 1, 0, 2'd3);

        // Back-pressure: five stalled RESP cycles, completes on the sixth.
        i_redir_ready = 1'b0;
        push(32'h800, 1, 0, 2'd3);
        issue(KIND_COND, F3_BGEU, 32'h700, 32'h100, 32'h5, 32'h5);
        @(posedge i_clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("stall_valid", {31'd0, o_redir_valid}, 32'd1);
            chk("stall_pc", o_redir_pc, 32'h800);
            chk("stall_taken", {31'd0, o_taken}, 32'd1);
            chk("stall_ready", {31'd0, o_br_ready}, 32'd0);
        end
        @(posedge i_clk); #1;
        i_redir_ready = 1'b1;
        @(posedge i_clk); #1;

        // Saturation run from a fresh reset.
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] pc;
            logic [CW-1:0] c;
            pc = 32'hB00 + 32'(i) * 32'h10;
            c = (i < 3) ? CW'(i + 1) : CW'(3);
            run_op(KIND_COND, F3_BNE, pc, 32'h40, 32'h1, 32'h2, pc + 32'h40, 1, 0, c);
        end
        @(negedge i_clk);
        @(negedge i_clk);

        // Reset while holding a result in RESP.
        i_redir_ready = 1'b0;
        issue(KIND_COND, F3_BNE, 32'hC00, 32'h40, 32'h1, 32'h2);
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        i_redir_ready = 1'b1;
        @(negedge i_clk);
        chk("rstmid_valid", {31'd0, o_redir_valid}, 32'd0);
        chk("rstmid_pc", o_redir_pc, 32'd0);
        chk("rstmid_taken", {31'd0, o_taken}, 32'd0);
        chk("rstmid_mis", {31'd0, o_misalign}, 32'd0);
        chk("rstmid_cnt", {30'd0, o_taken_cnt}, 32'd0);
        chk("rstmid_ready", {31'd0, o_br_ready}, 32'd1);

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("sb_drained", sb_q.size(), 32'd0);
        repeat (2) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
